// File: rtl/grf_wport_arb_if.sv
// GRF write-port bundle: W-stage request, MDU valid/ready request, registered GRF port
// and debug visibility of the arbiter state and starvation counter.
interface grf_wport_arb_if #(
    parameter int CNT_W = 2
);
    // W stage has no ready; it must present w_we=0 whenever stall_out=1.
    // MDU transfer completes in any cycle with mdu_valid=1 and mdu_ready=1; the
    // MDU holds mdu_valid and its payload stable until then.
    logic             w_we;
    logic [4:0]       w_a3;
    logic [31:0]      w_wd;
    logic [31:0]      w_pc;
    logic             mdu_valid;
    logic [4:0]       mdu_a3;
    logic [31:0]      mdu_wd;
    logic [31:0]      mdu_pc;
    logic             mdu_ready;
    logic             stall_out;
    logic             grf_we;
    logic [4:0]       grf_a3;
    logic [31:0]      grf_wd;
    logic [31:0]      grf_pc;
    logic [1:0]       dbg_state;
    logic [CNT_W-1:0] dbg_wait_cnt;

    modport master (
        output w_we, w_a3, w_wd, w_pc, mdu_valid, mdu_a3, mdu_wd, mdu_pc,
        input  mdu_ready, stall_out, grf_we, grf_a3, grf_wd, grf_pc,
        input  dbg_state, dbg_wait_cnt
    );

    modport slave (
        input  w_we, w_a3, w_wd, w_pc, mdu_valid, mdu_a3, mdu_wd, mdu_pc,
        output mdu_ready, stall_out, grf_we, grf_a3, grf_wd, grf_pc,
        output dbg_state, dbg_wait_cnt
    );
endinterface

// File: rtl/grf_wport_arb.sv
// Single GRF write port shared by the W stage and a multi-cycle MDU. W normally wins;
// a starved MDU result is forced in and the displaced W write parks in a 1-entry hold.
module grf_wport_arb #(
    parameter int STARVE_LIMIT = 3
) (
    input  logic            clk,
    input  logic            reset,
    grf_wport_arb_if.slave  bus
);
    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MWAIT = 2'd1,
        S_FORCE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_wait_nxt;
    logic [4:0]       r_hold_a3;
    logic [31:0]      r_hold_wd;
    logic [31:0]      r_hold_pc;
    logic             r_grf_we;
    logic [4:0]       r_grf_a3;
    logic [31:0]      r_grf_wd;
    logic [31:0]      r_grf_pc;
    logic             w_hold_valid;
    logic             w_grant;
    logic             w_capture;
    logic             w_sel_we;
    logic [4:0]       w_sel_a3;
    logic [31:0]      w_sel_wd;
    logic [31:0]      w_sel_pc;

    // The hold entry is full exactly while the FSM sits in FORCE.
    assign w_hold_valid = (r_state == S_FORCE);

    always_comb begin
        w_state_nxt = S_IDLE;
        w_wait_nxt  = r_wait_cnt;
        w_grant     = 1'b0;
        w_capture   = 1'b0;
        w_sel_we    = 1'b0;
        w_sel_a3    = r_grf_a3;
        w_sel_wd    = r_grf_wd;
        w_sel_pc    = r_grf_pc;

        if (w_hold_valid) begin
            // Any w_we presented now is a protocol violation and is dropped.
            w_sel_we = 1'b1;
            w_sel_a3 = r_hold_a3;
            w_sel_wd = r_hold_wd;
            w_sel_pc = r_hold_pc;
        end else if (bus.mdu_valid && bus.w_we && (bus.w_a3 == bus.mdu_a3) && (bus.w_a3 != 5'd0)) begin
            // Younger W overwrites the same register, so the MDU result is dead.
            w_grant    = 1'b1;
            w_wait_nxt = '0;
            w_sel_we   = 1'b1;
            w_sel_a3   = bus.w_a3;
            w_sel_wd   = bus.w_wd;
            w_sel_pc   = bus.w_pc;
        end else if (bus.mdu_valid && (!bus.w_we || (bus.w_a3 == 5'd0))) begin
            w_grant    = 1'b1;
            w_wait_nxt = '0;
            w_sel_we   = 1'b1;
            w_sel_a3   = bus.mdu_a3;
            w_sel_wd   = bus.mdu_wd;
            w_sel_pc   = bus.mdu_pc;
        end else if (bus.mdu_valid && (r_wait_cnt == LIMIT)) begin
            w_grant    = 1'b1;
            w_capture  = 1'b1;
            w_wait_nxt = '0;
            w_sel_we   = 1'b1;
            w_sel_a3   = bus.mdu_a3;
            w_sel_wd   = bus.mdu_wd;
            w_sel_pc   = bus.mdu_pc;
        end else if (bus.w_we) begin
            w_sel_we = 1'b1;
            w_sel_a3 = bus.w_a3;
            w_sel_wd = bus.w_wd;
            w_sel_pc = bus.w_pc;
            if (bus.mdu_valid && (r_wait_cnt != LIMIT)) begin
                w_wait_nxt = r_wait_cnt + CNT_W'(1);
            end
        end

        if (!bus.mdu_valid) begin
            w_wait_nxt = '0;
        end

        if (w_capture) begin
            w_state_nxt = S_FORCE;
        end else if (bus.mdu_valid && !w_grant) begin
            w_state_nxt = S_MWAIT;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
            r_hold_a3  <= 5'd0;
            r_hold_wd  <= 32'd0;
            r_hold_pc  <= 32'd0;
            r_grf_we   <= 1'b0;
            r_grf_a3   <= 5'd0;
            r_grf_wd   <= 32'd0;
            r_grf_pc   <= 32'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            if (w_capture) begin
                r_hold_a3 <= bus.w_a3;
                r_hold_wd <= bus.w_wd;
                r_hold_pc <= bus.w_pc;
            end
            // Destination 0 still updates the trace fields but never raises grf_we.
            r_grf_we <= w_sel_we && (w_sel_a3 != 5'd0);
            r_grf_a3 <= w_sel_a3;
            r_grf_wd <= w_sel_wd;
            r_grf_pc <= w_sel_pc;
        end
    end

    assign bus.mdu_ready    = reset && w_grant;
    assign bus.stall_out    = w_hold_valid;
    assign bus.grf_we       = r_grf_we;
    assign bus.grf_a3       = r_grf_a3;
    assign bus.grf_wd       = r_grf_wd;
    assign bus.grf_pc       = r_grf_pc;
    assign bus.dbg_state    = r_state;
    assign bus.dbg_wait_cnt = r_wait_cnt;
endmodule

// File: tb/tb_grf_wport_arb.sv
// Directed bench for grf_wport_arb: one task per scenario, inline checks against
// hand-computed values, single summary line at the end.
module tb_grf_wport_arb;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    grf_wport_arb_if bus_if ();

    grf_wport_arb #(.STARVE_LIMIT(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_w(input logic we, input logic [4:0] a3, input logic [31:0] wd, input logic [31:0] pc);
        bus_if.w_we = we;
        bus_if.w_a3 = a3;
        bus_if.w_wd = wd;
        bus_if.w_pc = pc;
    endtask

    task automatic set_mdu(input logic v, input logic [4:0] a3, input logic [31:0] wd, input logic [31:0] pc);
        bus_if.mdu_valid = v;
        bus_if.mdu_a3    = a3;
        bus_if.mdu_wd    = wd;
        bus_if.mdu_pc    = pc;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        set_w(1'b0, 5'd0, 32'd0, 32'd0);
        set_mdu(1'b1, 5'd3, 32'h55, 32'd0);
        repeat (2) cyc();
        n_checks++; if (bus_if.grf_we !== 1'b0) begin n_fail++; $display("FAIL reset_grf_we got %0b exp 0", bus_if.grf_we); end
        n_checks++; if (bus_if.grf_a3 !== 5'd0) begin n_fail++; $display("FAIL reset_grf_a3 got %0d exp 0", bus_if.grf_a3); end
        n_checks++; if (bus_if.grf_wd !== 32'd0) begin n_fail++; $display("FAIL reset_grf_wd got %0h exp 0", bus_if.grf_wd); end
        n_checks++; if (bus_if.grf_pc !== 32'd0) begin n_fail++; $display("FAIL reset_grf_pc got %0h exp 0", bus_if.grf_pc); end
        n_checks++; if (bus_if.mdu_ready !== 1'b0) begin n_fail++; $display("FAIL reset_mdu_ready got %0b exp 0", bus_if.mdu_ready); end
        n_checks++; if (bus_if.stall_out !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %0b exp 0", bus_if.stall_out); end
        n_checks++; if (bus_if.dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d exp 0", bus_if.dbg_state); end
        set_mdu(1'b0, 5'd0, 32'd0, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        cyc();
        n_checks++; if (bus_if.grf_we !== 1'b0) begin n_fail++; $display("FAIL post_reset_grf_we got %0b exp 0", bus_if.grf_we); end
    endtask

    task automatic test_idle_mdu();
        set_w(1'b1, 5'd5, 32'h11, 32'h100);
        #1;
        n_checks++; if (bus_if.mdu_ready !== 1'b0) begin n_fail++; $display("FAIL idle_mdu_ready got %0b exp 0", bus_if.mdu_ready); end
        cyc();
        set_w(1'b0, 5'd0, 32'd0, 32'd0);
        n_checks++; if (bus_if.grf_we !== 1'b1) begin n_fail++; $display("FAIL idle_grf_we got %0b exp 1", bus_if.grf_we); end
        n_checks++; if (bus_if.grf_a3 !== 5'd5) begin n_fail++; $display("FAIL idle_grf_a3 got %0d exp 5", bus_if.grf_a3); end
        n_checks++; if (bus_if.grf_wd !== 32'h11) begin n_fail++; $display("FAIL idle_grf_wd got %0h exp 11", bus_if.grf_wd); end
        n_checks++; if (bus_if.grf_pc !== 32'h100) begin n_fail++; $display("FAIL idle_grf_pc got %0h exp 100", bus_if.grf_pc); end
        #1;
        n_checks++; if (bus_if.mdu_ready !== 1'b0) begin n_fail++; $display("FAIL idle_mdu_ready2 got %0b exp 0", bus_if.mdu_ready); end
        cyc();
        n_checks++; if (bus_if.grf_we !== 1'b0) begin n_fail++; $display("FAIL idle_none_grf_we got %0b exp 0", bus_if.grf_we); end
    endtask

    task automatic test_free_slot();
        set_mdu(1'b1, 5'd8, 32'hAB, 32'h200);
        #1;
        n_checks++; if (bus_if.mdu_ready !== 1'b1) begin n_fail++; $display("FAIL free_mdu_ready got %0b exp 1", bus_if.mdu_ready); end
        cyc();
        set_mdu(1'b0, 5'd0, 32'd0, 32'd0);
        n_checks++; if (bus_if.grf_we !== 1'b1) begin n_fail++; $display("FAIL free_grf_we got %0b exp 1", bus_if.grf_we); end
        n_checks++; if (bus_if.grf_a3 !== 5'd8) begin n_fail++; $display("FAIL free_grf_a3 got %0d exp 8", bus_if.grf_a3); end
        n_checks++; if (bus_if.grf_wd !== 32'hAB) begin n_fail++; $display("FAIL free_grf_wd got %0h exp ab", bus_if.grf_wd); end
        n_checks++; if (bus_if.grf_pc !== 32'h200) begin n_fail++; $display("FAIL free_grf_pc got %0h exp 200", bus_if.grf_pc); end
    endtask

    task automatic test_same_dest();
        set_w(1'b1, 5'd7, 32'h1, 32'h300);
        set_mdu(1'b1, 5'd7, 32'h2, 32'h304);
        #1;
        n_checks++; if (bus_if.mdu_ready !== 1'b1) begin n_fail++; $display("FAIL same_mdu_ready got %0b exp 1", bus_if.mdu_ready); end
        cyc();
        set_w(1'b0, 5'd0, 32'd0, 32'd0);
        set_mdu(1'b0, 5'd0, 32'd0, 32'd0);
        n_checks++; if (bus_if.grf_we !== 1'b1) begin n_fail++; $display("FAIL same_grf_we got %0b exp 1", bus_if.grf_we); end
        n_checks++; if (bus_if.grf_a3 !== 5'd7) begin n_fail++; $display("FAIL same_grf_a3 got %0d exp 7", bus_if.grf_a3); end
        n_checks++; if (bus_if.grf_wd !== 32'h1) begin n_fail++; $display("FAIL same_grf_wd got %0h exp 1", bus_if.grf_wd); end
        cyc();
        n_checks++; if (bus_if.grf_we !== 1'b0) begin n_fail++; $display("FAIL same_no_second_write got %0b exp 0", bus_if.grf_we); end
    endtask

    task automatic test_zero_dest();
        set_mdu(1'b1, 5'd0, 32'h77, 32'h400);
        #1;
        n_checks++; if (bus_if.mdu_ready !== 1'b1) begin n_fail++; $display("FAIL zero_mdu_ready got %0b exp 1", bus_if.mdu_ready); end
        cyc();
        set_mdu(1'b0, 5'd0, 32'd0, 32'd0);
        n_checks++; if (bus_if.grf_we !== 1'b0) begin n_fail++; $display("FAIL zero_grf_we got %0b exp 0", bus_if.grf_we); end
    endtask

    task automatic test_starvation();
        set_mdu(1'b1, 5'd9, 32'h99, 32'h500);
        for (int i = 1; i <= 3; i++) begin
            set_w(1'b1, 5'(i), 32'h1000 + i, 32'h600 + 4 * i);
            #1;
            n_checks++; if (bus_if.mdu_ready !== 1'b0) begin n_fail++; $display("FAIL starve_ready_w%0d got %0b exp 0", i, bus_if.mdu_ready); end
            cyc();
            n_checks++; if (bus_if.grf_a3 !== 5'(i) || bus_if.grf_we !== 1'b1) begin n_fail++; $display("FAIL starve_w%0d got a3=%0d we=%0b exp a3=%0d we=1", i, bus_if.grf_a3, bus_if.grf_we, i); end
            n_checks++; if (bus_if.dbg_wait_cnt !== 2'(i)) begin n_fail++; $display("FAIL starve_cnt%0d got %0d exp %0d", i, bus_if.dbg_wait_cnt, i); end
        end
        set_w(1'b1, 5'd4, 32'h1004, 32'h610);
        #1;
        n_checks++; if (bus_if.mdu_ready !== 1'b1) begin n_fail++; $display("FAIL starve_force_ready got %0b exp 1", bus_if.mdu_ready); end
        cyc();
        set_mdu(1'b0, 5'd0, 32'd0, 32'd0);
        // protocol violation during stall: must be dropped
        set_w(1'b1, 5'd12, 32'hDEAD, 32'h700);
        n_checks++; if (bus_if.grf_a3 !== 5'd9 || bus_if.grf_wd !== 32'h99) begin n_fail++; $display("FAIL starve_mdu_write got a3=%0d wd=%0h exp a3=9 wd=99", bus_if.grf_a3, bus_if.grf_wd); end
        n_checks++; if (bus_if.stall_out !== 1'b1) begin n_fail++; $display("FAIL starve_stall got %0b exp 1", bus_if.stall_out); end
        n_checks++; if (bus_if.dbg_state !== 2'd2) begin n_fail++; $display("FAIL starve_state got %0d exp 2", bus_if.dbg_state); end
        #1;
        n_checks++; if (bus_if.mdu_ready !== 1'b0) begin n_fail++; $display("FAIL starve_hold_ready got %0b exp 0", bus_if.mdu_ready); end
        cyc();
        set_w(1'b0, 5'd0, 32'd0, 32'd0);
        n_checks++; if (bus_if.grf_a3 !== 5'd4 || bus_if.grf_wd !== 32'h1004 || bus_if.grf_we !== 1'b1) begin n_fail++; $display("FAIL starve_hold_write got a3=%0d wd=%0h exp a3=4 wd=1004", bus_if.grf_a3, bus_if.grf_wd); end
        n_checks++; if (bus_if.dbg_wait_cnt !== 2'd0) begin n_fail++; $display("FAIL starve_cnt_clear got %0d exp 0", bus_if.dbg_wait_cnt); end
        n_checks++; if (bus_if.stall_out !== 1'b0) begin n_fail++; $display("FAIL starve_stall_drop got %0b exp 0", bus_if.stall_out); end
        cyc();
        n_checks++; if (bus_if.grf_we !== 1'b0) begin n_fail++; $display("FAIL starve_dropped_w got we=%0b exp 0", bus_if.grf_we); end
        set_w(1'b1, 5'd5, 32'h1005, 32'h614);
        cyc();
        set_w(1'b0, 5'd0, 32'd0, 32'd0);
        n_checks++; if (bus_if.grf_a3 !== 5'd5 || bus_if.grf_we !== 1'b1) begin n_fail++; $display("FAIL starve_w5 got a3=%0d we=%0b exp a3=5 we=1", bus_if.grf_a3, bus_if.grf_we); end
    endtask

    task automatic test_abort();
        set_mdu(1'b1, 5'd11, 32'hBB, 32'h800);
        for (int i = 1; i <= 2; i++) begin
            set_w(1'b1, 5'(i + 20), 32'h2000 + i, 32'h900);
            cyc();
        end
        n_checks++; if (bus_if.dbg_wait_cnt !== 2'd2 || bus_if.dbg_state !== 2'd1) begin n_fail++; $display("FAIL abort_pending got cnt=%0d st=%0d exp cnt=2 st=1", bus_if.dbg_wait_cnt, bus_if.dbg_state); end
        set_mdu(1'b0, 5'd11, 32'hBB, 32'h800);
        set_w(1'b0, 5'd0, 32'd0, 32'd0);
        #1;
        n_checks++; if (bus_if.mdu_ready !== 1'b0) begin n_fail++; $display("FAIL abort_ready got %0b exp 0", bus_if.mdu_ready); end
        cyc();
        n_checks++; if (bus_if.grf_we !== 1'b0) begin n_fail++; $display("FAIL abort_grf_we got %0b exp 0", bus_if.grf_we); end
        n_checks++; if (bus_if.dbg_wait_cnt !== 2'd0 || bus_if.dbg_state !== 2'd0) begin n_fail++; $display("FAIL abort_clear got cnt=%0d st=%0d exp 0 0", bus_if.dbg_wait_cnt, bus_if.dbg_state); end
    endtask

    task automatic test_mid_reset();
        set_mdu(1'b1, 5'd10, 32'hCC, 32'hA00);
        for (int i = 1; i <= 4; i++) begin
            set_w(1'b1, 5'(i), 32'h3000 + i, 32'hB00);
            cyc();
        end
        set_mdu(1'b0, 5'd0, 32'd0, 32'd0);
        set_w(1'b0, 5'd0, 32'd0, 32'd0);
        n_checks++; if (bus_if.stall_out !== 1'b1 || bus_if.grf_we !== 1'b1) begin n_fail++; $display("FAIL midrst_setup got stall=%0b we=%0b exp 1 1", bus_if.stall_out, bus_if.grf_we); end
        #1;
        reset = 1'b0;
        #1;
        n_checks++; if (bus_if.grf_we !== 1'b0 || bus_if.grf_a3 !== 5'd0 || bus_if.grf_wd !== 32'd0) begin n_fail++; $display("FAIL midrst_async got we=%0b a3=%0d wd=%0h exp 0 0 0", bus_if.grf_we, bus_if.grf_a3, bus_if.grf_wd); end
        n_checks++; if (bus_if.stall_out !== 1'b0 || bus_if.dbg_state !== 2'd0) begin n_fail++; $display("FAIL midrst_stall got stall=%0b st=%0d exp 0 0", bus_if.stall_out, bus_if.dbg_state); end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc();
            n_checks++; if (bus_if.grf_we !== 1'b0) begin n_fail++; $display("FAIL midrst_stale%0d got we=%0b a3=%0d exp we=0", i, bus_if.grf_we, bus_if.grf_a3); end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_idle_mdu();
        test_free_slot();
        test_same_dest();
        test_zero_dest();
        test_starvation();
        test_abort();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/grf_wport_arb.md
GRF_WPORT_ARB -- requirements
Module: grf_wport_arb

Interface
REQ-001 Parameter STARVE_LIMIT, default 3: number of cycles a pending MDU write may lose arbitration before it is forced.
REQ-002 clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset; clears all state immediately on assertion.
REQ-004 w_we  in  1  pipeline W-stage write request; no backpressure, except via stall_out.
REQ-005 w_a3  in  5  W-stage destination register.
REQ-006 w_wd  in  32  W-stage write data.
REQ-007 w_pc  in  32  W-stage instruction PC.
REQ-008 mdu_valid  in  1  multi-cycle MDU result request; held stable until mdu_ready.
REQ-009 mdu_a3 / mdu_wd / mdu_pc  in  5/32/32  MDU destination register, data and PC.
REQ-010 mdu_ready  out  1  combinational grant; the MDU transfer completes in a cycle with mdu_valid=1 and mdu_ready=1.
REQ-011 stall_out  out  1  combinational; pipeline SHALL present w_we=0 in any cycle where it is 1.
REQ-012 grf_we / grf_a3 / grf_wd / grf_pc  out  1/5/32/32  registered GRF write port plus PC for trace.

Function
REQ-013 Every output register SHALL take the selected write one clock after the arbitration cycle (latency 1 cycle).
REQ-014 A request with destination 0 is a no-write: it is accepted or granted normally and produces grf_we=0.
REQ-015 Each cycle SHALL apply the first matching rule below, in priority order.
- P1: hold_valid=1 -> write the hold entry; stall_out=1; mdu_ready=0; hold cleared.
- P2: mdu_valid=1, w_we=1, w_a3=mdu_a3!=0 -> W written; mdu_ready=1; MDU result discarded (younger W wins); wait_cnt cleared.
- P3: mdu_valid=1 and (w_we=0 or w_a3=0) -> MDU written; mdu_ready=1; wait_cnt cleared.
- P4: mdu_valid=1, w_we=1, wait_cnt=STARVE_LIMIT -> MDU written; mdu_ready=1; W captured into hold; wait_cnt cleared.
- P5: w_we=1 -> W written; if mdu_valid=1, wait_cnt incremented.
- P6: none -> grf_we=0.
REQ-016 State machine: IDLE (mdu_valid=0, hold empty) -> MWAIT (MDU pending, wait_cnt counting) -> FORCE (cycle after P4, hold full) -> IDLE or MWAIT.
REQ-017 wait_cnt SHALL be ceil(log2(STARVE_LIMIT+1)) bits and SHALL saturate at STARVE_LIMIT.
REQ-018 wait_cnt SHALL clear whenever mdu_valid=0.
REQ-019 stall_out SHALL equal hold_valid.
REQ-020 A w_we=1 arriving while stall_out=1 is a protocol violation; it SHALL be ignored.
REQ-021 hold depth is exactly 1; hold SHALL never be overwritten while full.
REQ-022 mdu_valid deasserted before grant (abort) -> wait_cnt cleared; no write issued.
REQ-023 grf_we=1 SHALL never occur with grf_a3=0.

Reset
REQ-024 reset=0 SHALL asynchronously clear grf_we, grf_a3, grf_wd, grf_pc, hold_valid and wait_cnt, and force state IDLE.
REQ-025 During reset, mdu_ready=0 and stall_out=0.
REQ-026 A hold entry or pending MDU count is discarded by reset mid-operation.
REQ-027 The first arbitration occurs on the first rising edge after reset returns to 1.

Verification
REQ-028 Idle MDU: w_we=1, w_a3=5, w_wd=0x11 -> next cycle grf_we=1, grf_a3=5, grf_wd=0x11; mdu_ready never 1.
REQ-029 Free slot: mdu_valid=1, a3=8, wd=0xAB, w_we=0 -> same-cycle mdu_ready=1; next cycle grf_a3=8, grf_wd=0xAB.
REQ-030 Starvation, STARVE_LIMIT=3: w_we=1 every cycle to regs 1..5, mdu_valid=1 a3=9:
- 3 W writes occur first;
- 4th cycle: mdu_ready=1 and reg 9 is written;
- following cycle: stall_out=1 and the held W is written;
- wait_cnt is 0 afterwards.
REQ-031 Same destination: w_we=1, w_a3=mdu_a3=7, w_wd=0x1, mdu_wd=0x2 -> mdu_ready=1; next cycle only grf_wd=0x1 to reg 7.
REQ-032 Zero destination: mdu_valid=1, mdu_a3=0 -> mdu_ready=1; next cycle grf_we=0.
REQ-033 Mid-operation reset: assert reset=0 while hold is full (stall_out=1) -> outputs clear immediately without a clock edge; after release, no stale write appears.
